mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline MEM stage, directly downstream of the AGEX latch and upstream of WB.
- Passes ALU results through in one cycle.
- Performs LW/SW over a ready/valid data-memory port with variable latency, and stalls upstream while an access is outstanding.
- Drives the MEM→WB latch, the MEM→DE forwarding/hazard bundle, and a stall-cycle performance counter.

Parameters:
- DBITS, 32, data/address width
- INSTBITS, 32, instruction width
- IOPBITS, 6, internal opcode width (must match shared opcode constants)
- CNTBITS, 32, stall counter width

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  AGEX latch holds a real instruction
- in_pc  in  DBITS  PC of instruction
- in_inst  in  INSTBITS  raw instruction
- in_op  in  IOPBITS  internal opcode (LW_I, SW_I, others)
- in_dest  in  5  destination register
- in_wr_reg  in  1  instruction writes a register
- in_result  in  DBITS  ALU result; store data for SW
- in_mem_addr  in  DBITS  effective address for LW/SW
- dmem_req_valid  out  1  memory request valid
- dmem_req_we  out  1  1=store, 0=load
- dmem_req_addr  out  DBITS  word-aligned address
- dmem_req_wdata  out  DBITS  store data
- dmem_req_ready  in  1  memory accepts request this cycle
- dmem_resp_valid  in  1  load data valid
- dmem_resp_rdata  in  DBITS  load data
- stall_out  out  1  hold AGEX latch and everything upstream
- wb_valid  out  1  WB latch valid
- wb_pc  out  DBITS
- wb_inst  out  INSTBITS
- wb_op  out  IOPBITS
- wb_dest  out  5
- wb_wr_reg  out  1
- wb_value  out  DBITS  value to write back
- fwd_busy  out  1  load in flight whose dest is not yet available
- fwd_dest  out  5  dest of the instruction currently owned by MEM
- stall_cycles  out  CNTBITS  saturating count of cycles with stall_out=1

Behaviour:
- FSM states: IDLE, REQ, WAIT; held in registers.
- IDLE, in_valid=0: WB latch gets a bubble (wb_valid=0, wb_wr_reg=0).
- IDLE, non-memory op:
  - Next edge: WB latch gets pc/inst/op/dest and wb_value=in_result.
  - wb_wr_reg = in_wr_reg & (in_dest!=0). Latency 1, no stall.
- IDLE, LW or SW:
  - Capture the instruction into an internal hold register; go to REQ.
  - stall_out=1 combinationally in this same cycle.
  - WB latch gets a bubble.
- REQ:
  - dmem_req_valid=1; addr = held mem_addr with bits [1:0] forced 0; we=1 for SW; wdata = held result.
  - Outputs stay stable until dmem_req_ready=1.
  - On ready, SW: next edge writes WB latch with wb_valid=1, wb_wr_reg=0; go to IDLE.
  - On ready, LW: go to WAIT.
- WAIT:
  - dmem_req_valid=0.
  - On dmem_resp_valid: next edge writes WB latch with wb_value=rdata and wb_wr_reg=(dest!=0); go to IDLE.
- stall_out = (state!=IDLE) | (state==IDLE & in_valid & op∈{LW,SW}), with one exception:
  - stall_out=0 in the cycle the FSM returns to IDLE, so AGEX advances on that same edge.
  - Back-to-back memory ops therefore have 0 bubble cycles between completion and the next capture.
- dmem_resp_valid outside WAIT is ignored. The memory guarantees the response is no earlier than the cycle after the ready handshake.
- Forwarding to DE:
  - fwd_busy=1 while state∈{REQ,WAIT} and the held op is LW with dest!=0.
  - fwd_dest = held dest when busy, else in_dest.
- Performance counter:
  - stall_cycles increments each cycle stall_out=1; saturates at all-ones; never wraps.
- Reset:
  - Returns to IDLE from any state, including mid-REQ or mid-WAIT. The outstanding access is abandoned; memory shares the reset.
  - All wb_* outputs go to 0, dmem_req_valid=0, stall_cycles=0, fwd_busy=0.
  - Outputs are 0 the cycle after reset is sampled.

Decomposition:
- Shared package/define header holds:
  - opcode constants LW_I, SW_I
  - widths DBITS, INSTBITS, IOPBITS
  - MEM→WB and MEM→DE bundle widths (from_MEM_to_DE_WIDTH, MEM_latch_WIDTH)
  - FSM state encodings
- One sub-module is natural: sat_counter (parameterised width, enable, synchronous reset), used for stall_cycles.

Test Plan:
- ADD, in_result=0x1234, dest=5 → next cycle wb_valid=1, wb_value=0x1234, wb_wr_reg=1, stall_out never 1.
- LW addr=0x103, ready after 2 cycles, resp rdata=0xDEADBEEF after 3 more:
  - dmem_req_addr=0x100 held stable.
  - fwd_busy=1 throughout.
  - wb_value=0xDEADBEEF one cycle after resp.
  - stall_cycles=6.
- SW addr=0x40, result=0xA5, ready immediately → one req cycle with we=1, wdata=0xA5; wb_wr_reg=0; stall_out high exactly 1 cycle.
- LW to dest=0 → wb_wr_reg=0 and fwd_busy=0 throughout.
- Back-to-back LW, LW each with 1-cycle latency → second request issues the cycle after the first WB write; no extra bubble.
- Reset asserted while in WAIT, then a stray resp_valid → state IDLE, wb_valid=0, dmem_req_valid=0, stall_cycles=0, response ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: opcodes, widths, bundle sizes, FSM states.
package mem_stage_pkg;

    localparam int DBITS_DEF    = 32;
    localparam int INSTBITS_DEF = 32;
    localparam int IOPBITS_DEF  = 6;

    // Internal opcodes shared with the decoder; these must stay in sync with it.
    localparam logic [IOPBITS_DEF-1:0] LW_I = 6'b010010;
    localparam logic [IOPBITS_DEF-1:0] SW_I = 6'b011010;

    // MEM->DE bundle: {fwd_busy, fwd_dest}.
    localparam int from_MEM_to_DE_WIDTH = 1 + 5;
    // MEM->WB latch: {valid, pc, inst, op, dest, wr_reg, value}.
    localparam int MEM_latch_WIDTH = 1 + DBITS_DEF + INSTBITS_DEF + IOPBITS_DEF + 5 + 1 + DBITS_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_e;

    function automatic logic is_mem_op(input logic [IOPBITS_DEF-1:0] op);
        return (op == LW_I) || (op == SW_I);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Ready/valid data-memory port between the MEM stage (master) and memory (slave).
interface mem_stage_if
    import mem_stage_pkg::*;
#(
    parameter int DBITS = DBITS_DEF
);
    logic             dmem_req_valid;
    logic             dmem_req_we;
    logic [DBITS-1:0] dmem_req_addr;
    logic [DBITS-1:0] dmem_req_wdata;
    logic             dmem_req_ready;
    logic             dmem_resp_valid;
    logic [DBITS-1:0] dmem_resp_rdata;

    modport master (
        output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
    );
endinterface

// File: rtl/mem_stage_sat_counter.sv
// Saturating up-counter with enable and synchronous active-high reset.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q, count_d;

    // Next count: increment when enabled, stick at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: ALU pass-through, LW/SW over a ready/valid memory port,
// MEM->WB latch, MEM->DE forwarding info and a stall-cycle counter.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DBITS    = DBITS_DEF,
    parameter int INSTBITS = INSTBITS_DEF,
    parameter int IOPBITS  = IOPBITS_DEF,
    parameter int CNTBITS  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [DBITS-1:0]    in_pc,
    input  logic [INSTBITS-1:0] in_inst,
    input  logic [IOPBITS-1:0]  in_op,
    input  logic [4:0]          in_dest,
    input  logic                in_wr_reg,
    input  logic [DBITS-1:0]    in_result,
    input  logic [DBITS-1:0]    in_mem_addr,
    mem_stage_if.master         dmem,
    output logic                stall_out,
    output logic                wb_valid,
    output logic [DBITS-1:0]    wb_pc,
    output logic [INSTBITS-1:0] wb_inst,
    output logic [IOPBITS-1:0]  wb_op,
    output logic [4:0]          wb_dest,
    output logic                wb_wr_reg,
    output logic [DBITS-1:0]    wb_value,
    output logic                fwd_busy,
    output logic [4:0]          fwd_dest,
    output logic [CNTBITS-1:0]  stall_cycles
);
    mem_state_e state_q, state_d;

    // Instruction held while its memory access is outstanding.
    logic [DBITS-1:0]    h_pc_q,   h_pc_d;
    logic [INSTBITS-1:0] h_inst_q, h_inst_d;
    logic [IOPBITS-1:0]  h_op_q,   h_op_d;
    logic [4:0]          h_dest_q, h_dest_d;
    logic [DBITS-1:0]    h_data_q, h_data_d;
    logic [DBITS-1:0]    h_addr_q, h_addr_d;

    // WB latch.
    logic                wb_valid_q, wb_valid_d;
    logic [DBITS-1:0]    wb_pc_q,    wb_pc_d;
    logic [INSTBITS-1:0] wb_inst_q,  wb_inst_d;
    logic [IOPBITS-1:0]  wb_op_q,    wb_op_d;
    logic [4:0]          wb_dest_q,  wb_dest_d;
    logic                wb_wr_q,    wb_wr_d;
    logic [DBITS-1:0]    wb_value_q, wb_value_d;

    logic hold_ld;
    logic stall;
    logic held_is_sw;
    logic [from_MEM_to_DE_WIDTH-1:0] fwd_bus;

    assign held_is_sw = (h_op_q == SW_I);

    // FSM next state, hold-register load, WB latch contents and stall.
    always_comb begin
        state_d    = state_q;
        hold_ld    = 1'b0;
        stall      = 1'b0;
        wb_valid_d = 1'b0;
        wb_pc_d    = '0;
        wb_inst_d  = '0;
        wb_op_d    = '0;
        wb_dest_d  = '0;
        wb_wr_d    = 1'b0;
        wb_value_d = '0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_mem_op(in_op)) begin
                        // Capture and stall now; WB sees a bubble this edge.
                        hold_ld = 1'b1;
                        stall   = 1'b1;
                        state_d = REQ;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_pc_d    = in_pc;
                        wb_inst_d  = in_inst;
                        wb_op_d    = in_op;
                        wb_dest_d  = in_dest;
                        wb_wr_d    = in_wr_reg & (in_dest != 5'd0);
                        wb_value_d = in_result;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (dmem.dmem_req_ready) begin
                    if (held_is_sw) begin
                        // Store retires on the handshake; release AGEX on the same edge.
                        stall      = 1'b0;
                        state_d    = IDLE;
                        wb_valid_d = 1'b1;
                        wb_pc_d    = h_pc_q;
                        wb_inst_d  = h_inst_q;
                        wb_op_d    = h_op_q;
                        wb_dest_d  = h_dest_q;
                        wb_value_d = h_data_q;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (dmem.dmem_resp_valid) begin
                    stall      = 1'b0;
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_pc_d    = h_pc_q;
                    wb_inst_d  = h_inst_q;
                    wb_op_d    = h_op_q;
                    wb_dest_d  = h_dest_q;
                    wb_wr_d    = (h_dest_q != 5'd0);
                    wb_value_d = dmem.dmem_resp_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold-register next values.
    always_comb begin
        h_pc_d   = h_pc_q;
        h_inst_d = h_inst_q;
        h_op_d   = h_op_q;
        h_dest_d = h_dest_q;
        h_data_d = h_data_q;
        h_addr_d = h_addr_q;
        if (hold_ld) begin
            h_pc_d   = in_pc;
            h_inst_d = in_inst;
            h_op_d   = in_op;
            h_dest_d = in_dest;
            h_data_d = in_result;
            h_addr_d = in_mem_addr;
        end
    end

    // State and WB latch registers; reset abandons any outstanding access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b0;
            wb_pc_q    <= '0;
            wb_inst_q  <= '0;
            wb_op_q    <= '0;
            wb_dest_q  <= '0;
            wb_wr_q    <= 1'b0;
            wb_value_q <= '0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            wb_pc_q    <= wb_pc_d;
            wb_inst_q  <= wb_inst_d;
            wb_op_q    <= wb_op_d;
            wb_dest_q  <= wb_dest_d;
            wb_wr_q    <= wb_wr_d;
            wb_value_q <= wb_value_d;
        end
    end

    // Hold registers carry data only; they are qualified by the FSM state.
    always_ff @(posedge clk) begin
        h_pc_q   <= h_pc_d;
        h_inst_q <= h_inst_d;
        h_op_q   <= h_op_d;
        h_dest_q <= h_dest_d;
        h_data_q <= h_data_d;
        h_addr_q <= h_addr_d;
    end

    assign dmem.dmem_req_valid = (state_q == REQ);
    assign dmem.dmem_req_we    = held_is_sw;
    assign dmem.dmem_req_addr  = {h_addr_q[DBITS-1:2], 2'b00};
    assign dmem.dmem_req_wdata = h_data_q;

    assign stall_out = stall;

    assign fwd_bus = {(state_q != IDLE) && (h_op_q == LW_I) && (h_dest_q != 5'd0),
                      ((state_q != IDLE) && (h_op_q == LW_I) && (h_dest_q != 5'd0)) ? h_dest_q : in_dest};
    assign {fwd_busy, fwd_dest} = fwd_bus;

    assign wb_valid  = wb_valid_q;
    assign wb_pc     = wb_pc_q;
    assign wb_inst   = wb_inst_q;
    assign wb_op     = wb_op_q;
    assign wb_dest   = wb_dest_q;
    assign wb_wr_reg = wb_wr_q;
    assign wb_value  = wb_value_q;

    sat_counter #(.WIDTH(CNTBITS)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall),
        .count (stall_cycles)
    );
endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage plus a narrow sat_counter instance.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam logic [5:0] ADD = 6'h01;

    typedef struct {
        logic [31:0] rst, v;
        logic [5:0]  op;
        logic [31:0] dest, wr, pc, res, addr, rdy, rv, rdata;
        logic [31:0] es, erq, ewe, eaddr, ewd, ebusy, efd;
        logic [31:0] ewbv, ewbwr, cv, ewbval, ewbpc, ecnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_pc, in_inst, in_result, in_mem_addr;
    logic [5:0]  in_op;
    logic [4:0]  in_dest;
    logic        in_wr_reg;
    logic        stall_out, wb_valid, wb_wr_reg, fwd_busy;
    logic [31:0] wb_pc, wb_inst, wb_value, stall_cycles;
    logic [5:0]  wb_op;
    logic [4:0]  wb_dest, fwd_dest;
    logic        sc_rst, sc_en;
    logic [2:0]  sc_count;

    int checks = 0;
    int failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mem_stage_if #(.DBITS(32)) dmem_if ();

    mem_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .in_op(in_op), .in_dest(in_dest), .in_wr_reg(in_wr_reg), .in_result(in_result),
        .in_mem_addr(in_mem_addr), .dmem(dmem_if), .stall_out(stall_out),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_op(wb_op),
        .wb_dest(wb_dest), .wb_wr_reg(wb_wr_reg), .wb_value(wb_value),
        .fwd_busy(fwd_busy), .fwd_dest(fwd_dest), .stall_cycles(stall_cycles)
    );

    sat_counter #(.WIDTH(3)) u_sc (.clk(clk), .reset(sc_rst), .en(sc_en), .count(sc_count));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input int unsigned rst, v, input logic [5:0] op,
        input int unsigned dest, wr, pc, res, addr, rdy, rv, rdata,
        input int unsigned es, erq, ewe, eaddr, ewd, ebusy, efd,
        input int unsigned ewbv, ewbwr, cv, ewbval, ewbpc, ecnt);
        vec_t r;
        r.rst = rst; r.v = v; r.op = op; r.dest = dest; r.wr = wr; r.pc = pc;
        r.res = res; r.addr = addr; r.rdy = rdy; r.rv = rv; r.rdata = rdata;
        r.es = es; r.erq = erq; r.ewe = ewe; r.eaddr = eaddr; r.ewd = ewd;
        r.ebusy = ebusy; r.efd = efd; r.ewbv = ewbv; r.ewbwr = ewbwr; r.cv = cv;
        r.ewbval = ewbval; r.ewbpc = ewbpc; r.ecnt = ecnt;
        return r;
    endfunction

    initial begin
        // Columns: rst,v,op,dest,wr,pc,res,addr | rdy,rv,rdata | stall,reqv,we,addr,wdata,busy,fdest | wbv,wbwr,cv,wbval,wbpc,cnt
        // ALU pass-through, bubble with stray response, dest=0, wr_reg=0
        vecs.push_back(mk(0,1,ADD,5,1,'h10,'h1234,0, 0,0,0, 0,0,0,0,0,0,5, 1,1,1,'h1234,'h10,0));
        vecs.push_back(mk(0,0,ADD,0,0,0,0,0, 0,1,'hBAD, 0,0,0,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,1,ADD,0,1,'h14,'h77,0, 0,0,0, 0,0,0,0,0,0,0, 1,0,1,'h77,'h14,0));
        vecs.push_back(mk(0,1,ADD,7,0,'h18,'h99,0, 0,0,0, 0,0,0,0,0,0,7, 1,0,1,'h99,'h18,0));
        // LW 0x103: ready on the 3rd REQ cycle, response on the 3rd WAIT cycle
        vecs.push_back(mk(0,1,LW_I,3,1,'h20,0,'h103, 0,0,0, 1,0,0,0,0,0,3, 0,0,0,0,0,1));
        vecs.push_back(mk(0,1,LW_I,3,1,'h20,0,'h103, 0,1,'hBAD, 1,1,0,'h100,0,1,3, 0,0,0,0,0,2));
        vecs.push_back(mk(0,1,LW_I,3,1,'h20,0,'h103, 0,0,0, 1,1,0,'h100,0,1,3, 0,0,0,0,0,3));
        vecs.push_back(mk(0,1,LW_I,3,1,'h20,0,'h103, 1,0,0, 1,1,0,'h100,0,1,3, 0,0,0,0,0,4));
        vecs.push_back(mk(0,1,LW_I,9,1,'h20,0,'h103, 0,0,0, 1,0,0,0,0,1,3, 0,0,0,0,0,5));
        vecs.push_back(mk(0,1,LW_I,9,1,'h20,0,'h103, 0,0,0, 1,0,0,0,0,1,3, 0,0,0,0,0,6));
        vecs.push_back(mk(0,1,LW_I,3,1,'h20,0,'h103, 0,1,'hDEADBEEF, 0,0,0,0,0,1,3, 1,1,1,'hDEADBEEF,'h20,6));
        // SW 0x40, ready immediately
        vecs.push_back(mk(0,1,SW_I,4,1,'h30,'hA5,'h40, 0,0,0, 1,0,0,0,0,0,4, 0,0,0,0,0,7));
        vecs.push_back(mk(0,1,SW_I,4,1,'h30,'hA5,'h40, 1,0,0, 0,1,1,'h40,'hA5,0,4, 1,0,0,0,'h30,7));
        // LW to r0
        vecs.push_back(mk(0,1,LW_I,0,1,'h40,0,'h200, 0,0,0, 1,0,0,0,0,0,0, 0,0,0,0,0,8));
        vecs.push_back(mk(0,1,LW_I,0,1,'h40,0,'h200, 1,0,0, 1,1,0,'h200,0,0,0, 0,0,0,0,0,9));
        vecs.push_back(mk(0,1,LW_I,0,1,'h40,0,'h200, 0,1,'h55, 0,0,0,0,0,0,0, 1,0,1,'h55,'h40,9));
        // Back-to-back LW, LW, then ADD
        vecs.push_back(mk(0,1,LW_I,6,1,'h50,0,'h300, 0,0,0, 1,0,0,0,0,0,6, 0,0,0,0,0,10));
        vecs.push_back(mk(0,1,LW_I,6,1,'h50,0,'h300, 1,0,0, 1,1,0,'h300,0,1,6, 0,0,0,0,0,11));
        vecs.push_back(mk(0,1,LW_I,6,1,'h50,0,'h300, 0,1,'h1111, 0,0,0,0,0,1,6, 1,1,1,'h1111,'h50,11));
        vecs.push_back(mk(0,1,LW_I,7,1,'h54,0,'h406, 0,0,0, 1,0,0,0,0,0,7, 0,0,0,0,0,12));
        vecs.push_back(mk(0,1,LW_I,7,1,'h54,0,'h406, 1,0,0, 1,1,0,'h404,0,1,7, 0,0,0,0,0,13));
        vecs.push_back(mk(0,1,LW_I,7,1,'h54,0,'h406, 0,1,'h2222, 0,0,0,0,0,1,7, 1,1,1,'h2222,'h54,13));
        vecs.push_back(mk(0,1,ADD,8,1,'h58,'h3333,0, 0,0,0, 0,0,0,0,0,0,8, 1,1,1,'h3333,'h58,13));
        // Reset in WAIT, then a stray response
        vecs.push_back(mk(0,1,LW_I,9,1,'h60,0,'h500, 0,0,0, 1,0,0,0,0,0,9, 0,0,0,0,0,14));
        vecs.push_back(mk(0,1,LW_I,9,1,'h60,0,'h500, 1,0,0, 1,1,0,'h500,0,1,9, 0,0,0,0,0,15));
        vecs.push_back(mk(1,1,LW_I,9,1,'h60,0,'h500, 0,0,0, 1,0,0,0,0,1,9, 0,0,1,0,0,0));
        vecs.push_back(mk(0,0,ADD,0,0,0,0,0, 0,1,'hBAD, 0,0,0,0,0,0,0, 0,0,0,0,0,0));

        // Initial reset
        reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; in_op = '0; in_dest = '0;
        in_wr_reg = 1'b0; in_result = '0; in_mem_addr = '0;
        dmem_if.dmem_req_ready = 1'b0; dmem_if.dmem_resp_valid = 1'b0; dmem_if.dmem_resp_rdata = '0;
        sc_rst = 1'b1; sc_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_wr_reg", 32'(wb_wr_reg), 0);
        chk("rst_wb_value", wb_value, 0);
        chk("rst_wb_pc", wb_pc, 0);
        chk("rst_req_valid", 32'(dmem_if.dmem_req_valid), 0);
        chk("rst_fwd_busy", 32'(fwd_busy), 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        chk("rst_sc", 32'(sc_count), 0);

        @(negedge clk);
        reset = 1'b0;
        sc_rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t t;
            t = vecs[i];
            reset       = t.rst[0];
            in_valid    = t.v[0];
            in_op       = t.op;
            in_dest     = t.dest[4:0];
            in_wr_reg   = t.wr[0];
            in_pc       = t.pc;
            in_inst     = t.pc ^ 32'h0000_0013;
            in_result   = t.res;
            in_mem_addr = t.addr;
            dmem_if.dmem_req_ready  = t.rdy[0];
            dmem_if.dmem_resp_valid = t.rv[0];
            dmem_if.dmem_resp_rdata = t.rdata;
            #2;
            chk($sformatf("v%0d_stall", i), 32'(stall_out), t.es);
            chk($sformatf("v%0d_req_valid", i), 32'(dmem_if.dmem_req_valid), t.erq);
            chk($sformatf("v%0d_fwd_busy", i), 32'(fwd_busy), t.ebusy);
            chk($sformatf("v%0d_fwd_dest", i), 32'(fwd_dest), t.efd);
            if (t.erq[0]) begin
                chk($sformatf("v%0d_req_addr", i), dmem_if.dmem_req_addr, t.eaddr);
                chk($sformatf("v%0d_req_we", i), 32'(dmem_if.dmem_req_we), t.ewe);
                if (t.ewe[0]) chk($sformatf("v%0d_req_wdata", i), dmem_if.dmem_req_wdata, t.ewd);
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), t.ewbv);
            chk($sformatf("v%0d_wb_wr_reg", i), 32'(wb_wr_reg), t.ewbwr);
            chk($sformatf("v%0d_stall_cycles", i), stall_cycles, t.ecnt);
            if (t.ewbv[0] || t.cv[0]) chk($sformatf("v%0d_wb_pc", i), wb_pc, t.ewbpc);
            if (t.cv[0]) chk($sformatf("v%0d_wb_value", i), wb_value, t.ewbval);
            @(negedge clk);
        end
        reset = 1'b0;
        in_valid = 1'b0;
        dmem_if.dmem_resp_valid = 1'b0;

        // Narrow saturating counter: counts, sticks at 7, holds when disabled
        sc_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("sc_count3", 32'(sc_count), 3);
        repeat (6) @(posedge clk);
        #1;
        chk("sc_saturate", 32'(sc_count), 7);
        @(negedge clk);
        sc_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("sc_hold", 32'(sc_count), 7);
        @(negedge clk);
        sc_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("sc_reset", 32'(sc_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
